// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and shared memory port of mem_arbiter.
// slave = arbiter side; master = requesters plus memory side.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        dm_err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_ack, mem_rdata,
    output if_ready, if_rdata, if_err, dm_ready, dm_rdata, dm_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_ack, mem_rdata,
    input  if_ready, if_rdata, if_err, dm_ready, dm_rdata, dm_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one memory port with per-access timeout abort.
// Define ARB_RR_EN for round-robin tie-break; otherwise data always wins ties.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  // states: IDLE grant | IF_ACC fetch on mem | DM_ACC data on mem | DONE one-cycle ready
  typedef enum logic [1:0] {S_IDLE, S_IF_ACC, S_DM_ACC, S_DONE} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_gnt_dm;
  logic        r_we;
  logic        r_err;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;
  logic [7:0]  r_tmo_cnt;

  logic        w_grant_dm;
  logic        w_grant_if;
  logic        w_start;
  logic        w_acc;
  logic        w_tmo_hit;
  logic        w_end;

`ifdef ARB_RR_EN
  logic r_last_dm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_dm <= 1'b0;
    end else if (w_start) begin
      r_last_dm <= w_grant_dm;
    end
  end

  assign w_grant_dm = bus.dm_req && (!bus.if_req || !r_last_dm);
`else
  assign w_grant_dm = bus.dm_req;
`endif

  assign w_grant_if = bus.if_req && !w_grant_dm;
  assign w_start    = (r_state == S_IDLE) && (w_grant_dm || w_grant_if);
  assign w_acc      = (r_state == S_IF_ACC) || (r_state == S_DM_ACC);
  // an ack on the final allowed cycle still wins over the abort
  assign w_tmo_hit  = (r_tmo_cnt == TMO_LAST) && !bus.mem_ack;
  assign w_end      = w_acc && (bus.mem_ack || w_tmo_hit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_dm) begin
          w_next = S_DM_ACC;
        end else if (w_grant_if) begin
          w_next = S_IF_ACC;
        end
      end
      S_IF_ACC, S_DM_ACC: begin
        if (w_end) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req  = 1'b0;
    bus.if_ready = 1'b0;
    bus.if_err   = 1'b0;
    bus.dm_ready = 1'b0;
    bus.dm_err   = 1'b0;
    case (r_state)
      S_IF_ACC, S_DM_ACC: bus.mem_req = 1'b1;
      S_DONE: begin
        bus.if_ready = ~r_gnt_dm;
        bus.if_err   = ~r_gnt_dm & r_err;
        bus.dm_ready = r_gnt_dm;
        bus.dm_err   = r_gnt_dm & r_err;
      end
      default: ;
    endcase
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.mem_we    = r_we;
  assign bus.mem_be    = r_be;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt_dm   <= 1'b0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_be       <= 4'h0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_if_rdata <= 32'h0;
      r_dm_rdata <= 32'h0;
      r_tmo_cnt  <= 8'h0;
    end else if (w_start) begin
      r_gnt_dm  <= w_grant_dm;
      r_we      <= w_grant_dm & bus.dm_we;
      r_be      <= w_grant_dm ? bus.dm_be    : 4'hF;
      r_addr    <= w_grant_dm ? bus.dm_addr  : bus.if_addr;
      r_wdata   <= w_grant_dm ? bus.dm_wdata : 32'h0;
      r_err     <= 1'b0;
      r_tmo_cnt <= 8'h0;
    end else if (w_acc) begin
      if (bus.mem_ack) begin
        r_err <= 1'b0;
        if (r_gnt_dm) begin
          r_dm_rdata <= r_we ? 32'h0 : bus.mem_rdata;
        end else begin
          r_if_rdata <= bus.mem_rdata;
        end
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
        if (w_tmo_hit) begin
          r_err <= 1'b1;
          if (r_gnt_dm) begin
            r_dm_rdata <= 32'h0;
          end else begin
            r_if_rdata <= 32'h0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level model checked every cycle plus literal expectations.
module tb_mem_arbiter;
  localparam int TMO = 15;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // memory responder: ack on the mem_lat-th cycle of mem_req (0 = never)
  int          mem_lat      = 1;
  bit          mem_fixed_en = 1'b0;
  logic [31:0] mem_fixed    = 32'h0;
  bit          spurious     = 1'b0;
  int          acc_cyc      = 0;

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_req) acc_cyc++;
      else acc_cyc = 0;
      if (bus.mem_req && mem_lat != 0 && acc_cyc == mem_lat) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_fixed_en ? mem_fixed : bus.mem_addr + 32'h1000_0000;
      end else begin
        bus.mem_ack   = spurious;
        bus.mem_rdata = spurious ? 32'hBAD0_BAD0 : 32'h0;
      end
    end
  end

  // transaction-level model: owner 0 none, 1 fetch, 2 data
  int          m_owner = 0;
  int          m_wait  = 0;
  bit          m_done  = 1'b0;
  bit          m_err   = 1'b0;
  bit          m_last_dm = 1'b0;
  logic        m_we    = 1'b0;
  logic [3:0]  m_be    = 4'h0;
  logic [31:0] m_addr  = 32'h0;
  logic [31:0] m_wdata = 32'h0;
  logic [31:0] m_rd_if = 32'h0;
  logic [31:0] m_rd_dm = 32'h0;
  logic        prev_req = 1'b0;
  logic [68:0] glog[$];

  initial begin
    bit e_act, e_if, e_dm, g_dm;
    logic [31:0] rd;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_owner = 0; m_wait = 0; m_done = 0; m_err = 0; m_last_dm = 0;
        m_rd_if = 0; m_rd_dm = 0; prev_req = 0;
        chk("rst_ctl", {bus.busy, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata,
                        bus.if_ready, bus.if_err, bus.dm_ready, bus.dm_err}, 128'h0);
        chk("rst_rdata", {bus.if_rdata, bus.dm_rdata}, 128'h0);
      end else begin
        e_act = (m_owner != 0) && !m_done;
        e_if  = m_done && (m_owner == 1);
        e_dm  = m_done && (m_owner == 2);
        chk("cycle_ctl", {bus.busy, bus.mem_req, bus.if_ready, bus.if_err, bus.dm_ready, bus.dm_err},
            {m_owner != 0, e_act, e_if, e_if && m_err, e_dm, e_dm && m_err});
        chk("cycle_if_rdata", bus.if_rdata, m_rd_if);
        chk("cycle_dm_rdata", bus.dm_rdata, m_rd_dm);
        if (e_act)
          chk("cycle_mem_bus", {bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata},
              {m_we, m_be, m_addr, m_wdata});
        if (bus.mem_req && !prev_req)
          glog.push_back({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata});
        prev_req = bus.mem_req;

        if (m_owner == 0) begin
          g_dm = bus.dm_req && (!bus.if_req || !RR || !m_last_dm);
          if (g_dm) begin
            m_owner = 2; m_addr = bus.dm_addr; m_we = bus.dm_we; m_be = bus.dm_be;
            m_wdata = bus.dm_wdata; m_last_dm = 1;
          end else if (bus.if_req) begin
            m_owner = 1; m_addr = bus.if_addr; m_we = 0; m_be = 4'hF;
            m_wdata = 0; m_last_dm = 0;
          end
          m_wait = 0;
          m_done = 0;
        end else if (!m_done) begin
          m_wait++;
          if (bus.mem_ack) begin
            m_done = 1; m_err = 0;
            rd = m_we ? 32'h0 : bus.mem_rdata;
          end else if (m_wait == TMO) begin
            m_done = 1; m_err = 1; rd = 32'h0;
          end
          if (m_done) begin
            if (m_owner == 2) m_rd_dm = rd;
            else m_rd_if = rd;
          end
        end else begin
          m_owner = 0;
          m_done  = 0;
        end
      end
    end
  end

  // lat = cycles from the request cycle to the cycle ready is seen
  task automatic access(input bit is_dm, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output int lat, output logic [31:0] rd, output logic err);
    bit seen;
    seen = 0; lat = 0; rd = 0; err = 0;
    if (is_dm) begin
      bus.dm_req = 1; bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wdata; bus.dm_be = be;
    end else begin
      bus.if_req = 1; bus.if_addr = addr;
    end
    for (int i = 1; i <= 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (is_dm ? bus.dm_ready : bus.if_ready) begin
        seen = 1;
        lat  = i;
        rd   = is_dm ? bus.dm_rdata : bus.if_rdata;
        err  = is_dm ? bus.dm_err : bus.if_err;
      end
    end
    chk("wait_ready", seen, 1'b1);
    @(posedge clk);
    #1;
    if (is_dm) bus.dm_req = 0;
    else bus.if_req = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, lat_b, n0, nrdy;
    logic [31:0] rd, rd_b;
    logic        err, err_b;
    logic [68:0] ent;
    logic [31:0] exp_ord[4];
    logic [31:0] ent_addr;

    bus.if_req = 0; bus.if_addr = 0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0; bus.dm_be = 0;
    repeat (3) @(posedge clk);
    #3 rst = 1;
    @(posedge clk);
    #1;

    // fetch read at minimum latency
    mem_fixed_en = 1; mem_fixed = 32'h0050_0093; mem_lat = 1;
    access(0, 0, 32'h100, 32'h0, 4'hF, lat, rd, err);
    chk("if_latency", lat, 2);
    chk("if_rdata", rd, 32'h0050_0093);
    chk("if_err", err, 1'b0);
    ent = glog[glog.size()-1];
    chk("if_mem_bus", ent, {1'b0, 4'hF, 32'h100, 32'h0});
    mem_fixed_en = 0;

    // data write: latched we/be/wdata on the memory port, rdata loads 0
    access(1, 1, 32'h2000, 32'hDEAD_BEEF, 4'b0011, lat, rd, err);
    ent = glog[glog.size()-1];
    chk("wr_mem_bus", ent, {1'b1, 4'b0011, 32'h2000, 32'hDEAD_BEEF});
    chk("wr_latency", lat, 2);
    chk("wr_rdata", rd, 32'h0);

    // data read with slower memory
    mem_lat = 3;
    access(1, 0, 32'h3000, 32'h0, 4'hF, lat, rd, err);
    chk("rd3_latency", lat, 4);
    chk("rd3_rdata", rd, 32'h1000_3000);

    // no ack: abort after TIMEOUT access cycles
    mem_lat = 0;
    access(1, 0, 32'h3004, 32'h0, 4'hF, lat, rd, err);
    chk("tmo_latency", lat, TMO + 1);
    chk("tmo_err", err, 1'b1);
    chk("tmo_rdata", rd, 32'h0);
    chk("tmo_idle", bus.busy, 1'b0);

    // fetch ack one cycle before the limit
    mem_lat = TMO - 1;
    access(0, 0, 32'h104, 32'h0, 4'hF, lat, rd, err);
    chk("if14_latency", lat, TMO);
    chk("if14_rdata", rd, 32'h1000_0104);

    // ack exactly on the last allowed cycle is a success
    mem_lat = TMO;
    access(1, 0, 32'h4000, 32'h0, 4'hF, lat, rd, err);
    chk("edge_latency", lat, TMO + 1);
    chk("edge_err", err, 1'b0);
    chk("edge_rdata", rd, 32'h1000_4000);
    chk("if_rdata_hold", bus.if_rdata, 32'h1000_0104);

    // ack while idle is ignored
    spurious = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("spurious_busy", bus.busy, 1'b0);
    spurious = 0;

    // simultaneous requests, four back-to-back accesses
    mem_lat = 1;
    n0 = glog.size();
    fork
      begin
        access(0, 0, 32'h0100, 32'h0, 4'hF, lat, rd, err);
        access(0, 0, 32'h0104, 32'h0, 4'hF, lat, rd, err);
      end
      begin
        access(1, 0, 32'h2000, 32'h0, 4'hF, lat_b, rd_b, err_b);
        access(1, 0, 32'h2004, 32'h0, 4'hF, lat_b, rd_b, err_b);
      end
    join
    if (RR) begin
      exp_ord[0] = 32'h2000; exp_ord[1] = 32'h0100; exp_ord[2] = 32'h2004; exp_ord[3] = 32'h0104;
    end else begin
      exp_ord[0] = 32'h2000; exp_ord[1] = 32'h2004; exp_ord[2] = 32'h0100; exp_ord[3] = 32'h0104;
    end
    chk("tie_count", glog.size() - n0, 4);
    for (int k = 0; k < 4; k++) begin
      if (n0 + k < glog.size()) ent = glog[n0 + k];
      else ent = '0;
      ent_addr = ent[63:32];
      chk($sformatf("tie_order%0d", k), ent_addr, exp_ord[k]);
    end

    // reset in the middle of a fetch access
    mem_lat = 0;
    bus.if_req = 1; bus.if_addr = 32'h200;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_mem_req", bus.mem_req, 1'b1);
    #2 rst = 0;
    #1;
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    bus.if_req = 0;
    nrdy = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.if_ready) nrdy++;
    end
    bus.if_req = 1; bus.if_addr = 32'h204; mem_lat = 1;
    #2 rst = 1;
    @(posedge clk);
    #1;
    chk("post_rst_grant", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h204});
    @(posedge clk);
    #1;
    chk("post_rst_ready", {bus.if_ready, bus.if_err, bus.if_rdata}, {1'b1, 1'b0, 32'h1000_0204});
    nrdy += 0;
    chk("no_stale_ready", nrdy, 0);
    @(posedge clk);
    #1;
    bus.if_req = 0;

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
